// File: rtl/scr_ram_arb.sv
// Screen RAM arbiter: display reads, buffered host writes, block-fill engine.
// Fixed priority display > host FIFO > fill; one RAM access per cycle.
module scr_ram_arb #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  input  logic              host_wr,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_data,
  output logic              host_full,
  input  logic              fill_start,
  input  logic [ADDR_W-1:0] fill_addr,
  input  logic [ADDR_W-1:0] fill_len,
  input  logic [DATA_W-1:0] fill_data,
  output logic              fill_busy,
  output logic              ovf,
  input  logic              ovf_clr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic {IDLE, RUN} fill_st_t;

  fill_st_t          st;
  logic [ADDR_W-1:0] fq_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] fq_data [FIFO_DEPTH];
  logic [PW-1:0]     wp, rp;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [ADDR_W-1:0] cur, rem;
  logic [DATA_W-1:0] fval;

  logic fifo_empty, host_gnt, fill_gnt;
  logic push, drop;

  assign fifo_empty = (cnt == '0);
  assign host_gnt   = !disp_req && !fifo_empty;
  assign fill_gnt   = !disp_req && fifo_empty && (st == RUN);
  // full is the registered view of cnt, so a pop cannot rescue a push
  assign push       = host_wr && !host_full;
  assign drop       = host_wr && host_full;

  assign disp_data  = ram_rdata;
  assign fill_busy  = (st == RUN);

  always_comb begin
    cnt_nxt = cnt;
    unique case ({push, host_gnt})
      2'b10:   cnt_nxt = cnt + CW'(1);
      2'b01:   cnt_nxt = cnt - CW'(1);
      default: cnt_nxt = cnt;
    endcase
  end

  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    ram_we    = 1'b0;
    unique case (1'b1)
      disp_req: ram_addr = disp_addr;
      host_gnt: begin
        ram_addr  = fq_addr[rp];
        ram_wdata = fq_data[rp];
        ram_we    = 1'b1;
      end
      fill_gnt: begin
        ram_addr  = cur;
        ram_wdata = fval;
        ram_we    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fq_addr[wp] <= host_addr;
      fq_data[wp] <= host_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp         <= '0;
      rp         <= '0;
      cnt        <= '0;
      host_full  <= 1'b0;
      ovf        <= 1'b0;
      disp_valid <= 1'b0;
    end else begin
      disp_valid <= disp_req;
      cnt        <= cnt_nxt;
      host_full  <= (cnt_nxt == DEPTH_C);
      if (push)
        wp <= wp + PW'(1);
      if (host_gnt)
        rp <= rp + PW'(1);
      if (drop)
        ovf <= 1'b1;
      else if (ovf_clr)
        ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st   <= IDLE;
      cur  <= '0;
      rem  <= '0;
      fval <= '0;
    end else begin
      unique case (st)
        IDLE: begin
          if (fill_start && fill_len != '0) begin
            st   <= RUN;
            cur  <= fill_addr;
            rem  <= fill_len;
            fval <= fill_data;
          end
        end
        RUN: begin
          if (fill_gnt) begin
            cur <= cur + ADDR_W'(1);
            rem <= rem - ADDR_W'(1);
            if (rem == ADDR_W'(1))
              st <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scr_ram_arb.sv
// Directed bench for scr_ram_arb with a behavioural sync-read RAM
// that logs every write (address, data, cycle).
module tb_scr_ram_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        disp_req;
  logic [15:0] disp_addr;
  logic [7:0]  disp_data;
  logic        disp_valid;
  logic        host_wr;
  logic [15:0] host_addr;
  logic [7:0]  host_data;
  logic        host_full;
  logic        fill_start;
  logic [15:0] fill_addr;
  logic [15:0] fill_len;
  logic [7:0]  fill_data;
  logic        fill_busy;
  logic        ovf;
  logic        ovf_clr;
  logic [15:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_we;
  logic [7:0]  ram_rdata;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [7:0]  mem [0:65535];
  logic [15:0] la [$];
  logic [7:0]  ld [$];
  int          lc [$];

  always #5 clk = ~clk;

  scr_ram_arb dut (
    .clk(clk), .rst(rst),
    .disp_req(disp_req), .disp_addr(disp_addr),
    .disp_data(disp_data), .disp_valid(disp_valid),
    .host_wr(host_wr), .host_addr(host_addr),
    .host_data(host_data), .host_full(host_full),
    .fill_start(fill_start), .fill_addr(fill_addr),
    .fill_len(fill_len), .fill_data(fill_data),
    .fill_busy(fill_busy), .ovf(ovf), .ovf_clr(ovf_clr),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_we(ram_we), .ram_rdata(ram_rdata)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
      la.push_back(ram_addr);
      ld.push_back(ram_wdata);
      lc.push_back(cyc);
    end
    ram_rdata <= mem[ram_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_log();
    la.delete();
    ld.delete();
    lc.delete();
  endtask

  task automatic idle_inputs();
    disp_req   = 1'b0;
    disp_addr  = '0;
    host_wr    = 1'b0;
    host_addr  = '0;
    host_data  = '0;
    fill_start = 1'b0;
    fill_addr  = '0;
    fill_len   = '0;
    fill_data  = '0;
    ovf_clr    = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    tests++;
    if ({disp_valid, host_full, fill_busy, ovf} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_flags got %b want 0000",
               {disp_valid, host_full, fill_busy, ovf});
    end
    tests++;
    if (ram_we !== 1'b0 || ram_addr !== 16'h0 || ram_wdata !== 8'h0) begin
      fails++;
      $display("FAIL reset_ram got we=%b a=%h d=%h want 0",
               ram_we, ram_addr, ram_wdata);
    end
  endtask

  task automatic test_display();
    disp_req  = 1'b1;
    disp_addr = 16'h0123;
    #1;
    tests++;
    if (ram_we !== 1'b0 || ram_addr !== 16'h0123) begin
      fails++;
      $display("FAIL disp_issue got we=%b a=%h want 0/0123",
               ram_we, ram_addr);
    end
    tick();
    disp_req = 1'b0;
    tests++;
    if (disp_valid !== 1'b1 || disp_data !== 8'h41) begin
      fails++;
      $display("FAIL disp_data got v=%b d=%h want 1/41",
               disp_valid, disp_data);
    end
    tick();
    tests++;
    if (disp_valid !== 1'b0) begin
      fails++;
      $display("FAIL disp_valid_drop got %b want 0", disp_valid);
    end
  endtask

  task automatic test_host_order();
    clr_log();
    disp_req  = 1'b1;
    host_wr   = 1'b1;
    host_addr = 16'h0010;
    host_data = 8'hAA;
    tick();
    host_addr = 16'h0011;
    host_data = 8'hBB;
    tick();
    host_wr = 1'b0;
    tick();
    tests++;
    if (la.size() != 0) begin
      fails++;
      $display("FAIL host_blocked got %0d writes want 0", la.size());
    end
    disp_req = 1'b0;
    repeat (4) tick();
    tests++;
    if (la.size() != 2) begin
      fails++;
      $display("FAIL host_count got %0d want 2", la.size());
    end else begin
      tests++;
      if (la[0] !== 16'h0010 || ld[0] !== 8'hAA ||
          la[1] !== 16'h0011 || ld[1] !== 8'hBB) begin
        fails++;
        $display("FAIL host_order got %h=%h %h=%h want 0010=aa 0011=bb",
                 la[0], ld[0], la[1], ld[1]);
      end
      tests++;
      if (lc[1] != lc[0] + 1) begin
        fails++;
        $display("FAIL host_b2b got cycles %0d,%0d want consecutive",
                 lc[0], lc[1]);
      end
    end
  endtask

  task automatic test_overflow();
    clr_log();
    disp_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      host_wr   = 1'b1;
      host_addr = 16'h0020 + 16'(i);
      host_data = 8'h50 + 8'(i);
      tick();
      if (i == 3) begin
        tests++;
        if (host_full !== 1'b1 || ovf !== 1'b0) begin
          fails++;
          $display("FAIL ovf_full got full=%b ovf=%b want 1/0",
                   host_full, ovf);
        end
      end
    end
    host_wr = 1'b0;
    tests++;
    if (ovf !== 1'b1) begin
      fails++;
      $display("FAIL ovf_set got %b want 1", ovf);
    end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    tests++;
    if (ovf !== 1'b0) begin
      fails++;
      $display("FAIL ovf_clr got %b want 0", ovf);
    end
    disp_req = 1'b0;
    repeat (7) tick();
    tests++;
    if (la.size() != 4) begin
      fails++;
      $display("FAIL ovf_drain got %0d writes want 4", la.size());
    end else begin
      tests++;
      if (la[3] !== 16'h0023 || ld[3] !== 8'h53) begin
        fails++;
        $display("FAIL ovf_last got %h=%h want 0023=53", la[3], ld[3]);
      end
    end
    tests++;
    if (host_full !== 1'b0) begin
      fails++;
      $display("FAIL ovf_empty got full=%b want 0", host_full);
    end
  endtask

  task automatic test_fill_wrap();
    int busy_n;
    logic [15:0] exp_a [4];
    exp_a[0] = 16'hFFFE;
    exp_a[1] = 16'hFFFF;
    exp_a[2] = 16'h0000;
    exp_a[3] = 16'h0001;
    clr_log();
    busy_n     = 0;
    fill_start = 1'b1;
    fill_addr  = 16'hFFFE;
    fill_len   = 16'd4;
    fill_data  = 8'h20;
    tick();
    fill_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (fill_busy === 1'b1)
        busy_n++;
      tick();
    end
    tests++;
    if (busy_n != 4) begin
      fails++;
      $display("FAIL fill_busy_len got %0d want 4", busy_n);
    end
    tests++;
    if (la.size() != 4) begin
      fails++;
      $display("FAIL fill_count got %0d want 4", la.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (la[i] !== exp_a[i] || ld[i] !== 8'h20) begin
          fails++;
          $display("FAIL fill_wr%0d got %h=%h want %h=20",
                   i, la[i], ld[i], exp_a[i]);
        end
      end
    end
    clr_log();
    fill_start = 1'b1;
    fill_addr  = 16'h0300;
    fill_len   = 16'd0;
    fill_data  = 8'h55;
    tick();
    fill_start = 1'b0;
    tests++;
    if (fill_busy !== 1'b0) begin
      fails++;
      $display("FAIL fill_zero_busy got %b want 0", fill_busy);
    end
    repeat (4) tick();
    tests++;
    if (la.size() != 0) begin
      fails++;
      $display("FAIL fill_zero_wr got %0d writes want 0", la.size());
    end
  endtask

  task automatic test_contention();
    logic [15:0] exp_a [9];
    exp_a[0] = 16'h0100;
    exp_a[1] = 16'h0101;
    exp_a[2] = 16'h0200;
    for (int j = 3; j < 9; j++)
      exp_a[j] = 16'h0100 + 16'(j - 1);
    clr_log();
    fill_start = 1'b1;
    fill_addr  = 16'h0100;
    fill_len   = 16'd8;
    fill_data  = 8'h77;
    tick();
    fill_start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      disp_req   = (i % 2) == 1;
      disp_addr  = 16'h0400 + 16'(i);
      host_wr    = (i == 2);
      host_addr  = 16'h0200;
      host_data  = 8'h99;
      fill_start = (i == 4);
      fill_addr  = 16'h0300;
      fill_len   = 16'd3;
      fill_data  = 8'h11;
      #1;
      if (disp_req) begin
        tests++;
        if (ram_we !== 1'b0 || ram_addr !== disp_addr) begin
          fails++;
          $display("FAIL cont_disp%0d got we=%b a=%h want 0/%h",
                   i, ram_we, ram_addr, disp_addr);
        end
      end
      tick();
    end
    idle_inputs();
    tests++;
    if (fill_busy !== 1'b0) begin
      fails++;
      $display("FAIL cont_done got busy=%b want 0", fill_busy);
    end
    tests++;
    if (la.size() != 9) begin
      fails++;
      $display("FAIL cont_count got %0d want 9", la.size());
    end else begin
      for (int j = 0; j < 9; j++) begin
        tests++;
        if (la[j] !== exp_a[j] ||
            ld[j] !== ((j == 2) ? 8'h99 : 8'h77)) begin
          fails++;
          $display("FAIL cont_wr%0d got %h=%h want %h",
                   j, la[j], ld[j], exp_a[j]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    clr_log();
    fill_start = 1'b1;
    fill_addr  = 16'h0500;
    fill_len   = 16'd6;
    fill_data  = 8'h33;
    tick();
    fill_start = 1'b0;
    tick();
    tick();
    disp_req  = 1'b1;
    disp_addr = 16'h0600;
    host_wr   = 1'b1;
    host_addr = 16'h0700;
    host_data = 8'hC1;
    tick();
    host_addr = 16'h0701;
    host_data = 8'hC2;
    tick();
    host_wr = 1'b0;
    tests++;
    if (la.size() != 2 || fill_busy !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_setup got %0d writes busy=%b want 2/1",
               la.size(), fill_busy);
    end
    #2;
    disp_req = 1'b0;
    rst      = 1'b1;
    #1;
    tests++;
    if ({disp_valid, host_full, fill_busy, ovf} !== 4'b0000 ||
        ram_we !== 1'b0 || ram_addr !== 16'h0 || ram_wdata !== 8'h0) begin
      fails++;
      $display("FAIL rstmid_async got v=%b f=%b b=%b o=%b we=%b a=%h want 0",
               disp_valid, host_full, fill_busy, ovf, ram_we, ram_addr);
    end
    tick();
    tick();
    rst = 1'b0;
    repeat (12) tick();
    tests++;
    if (la.size() != 2) begin
      fails++;
      $display("FAIL rstmid_nowr got %0d writes want 2", la.size());
    end
  endtask

  initial begin
    mem[16'h0123] = 8'h41;
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_display();
    test_host_order();
    test_overflow();
    test_fill_wrap();
    test_contention();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/scr_ram_arb.md
# scr_ram_arb

Screen RAM access arbiter for the graphics adapter. It shares the single read/write port of `screen_ram` between three requesters: the active display controller's read fetches, host register-interface writes, and a hardware block-fill engine that clears or paints a range of screen memory. Display fetches are never delayed. Host writes are buffered in a small FIFO. The fill engine uses whatever cycles remain.

## Interface
Parameters:
- `ADDR_W`, 16, screen RAM address width
- `DATA_W`, 8, screen RAM data width
- `FIFO_DEPTH`, 4, host write FIFO entries (power of two, ≥2)

Ports:
- `clk`  in  1  fclock domain clock; everything is rising-edge
- `rst`  in  1  reset, asynchronous, active-high
- `disp_req`  in  1  display fetch request this cycle
- `disp_addr`  in  ADDR_W  display fetch address
- `disp_data`  out  DATA_W  fetch data; equals `ram_rdata`
- `disp_valid`  out  1  `disp_data` valid (registered)
- `host_wr`  in  1  push one host write
- `host_addr`  in  ADDR_W  host write address
- `host_data`  in  DATA_W  host write data
- `host_full`  out  1  FIFO holds FIFO_DEPTH entries
- `fill_start`  in  1  start a fill (1-cycle pulse)
- `fill_addr`  in  ADDR_W  fill base address
- `fill_len`  in  ADDR_W  number of bytes to fill; 0 means no-op
- `fill_data`  in  DATA_W  fill value
- `fill_busy`  out  1  fill engine in RUN
- `ovf`  out  1  sticky flag: a host write was dropped
- `ovf_clr`  in  1  clears `ovf`
- `ram_addr`  out  ADDR_W  RAM address (combinational)
- `ram_wdata`  out  DATA_W  RAM write data (combinational)
- `ram_we`  out  1  RAM write enable (combinational)
- `ram_rdata`  in  DATA_W  RAM read data, 1-cycle sync read

## Operation
- **Fixed priority each cycle:** display > host FIFO head > fill engine. At most one RAM access per cycle.
- **Display grant:**
  - `ram_addr=disp_addr`, `ram_we=0`.
  - `disp_valid` is 1 on the next cycle, with `disp_data` = that read.
- **Host grant** (FIFO non-empty, `disp_req=0`):
  - Drive the head's addr/data with `ram_we=1`, then pop.
- **Fill grant** (RUN, FIFO empty, `disp_req=0`):
  - Write `fill_data` at the current address `cur`.
  - `cur` increments modulo 2^ADDR_W (0xFFFF wraps to 0x0000).
  - `rem` decrements.
- **No grant:** `ram_addr=0`, `ram_wdata=0`, `ram_we=0`.
- **Host FIFO:**
  - A push is accepted when count < FIFO_DEPTH.
  - A push while `host_full=1` is dropped and sets `ovf`, even if a pop occurs in the same cycle.
  - Push and pop in the same cycle: count unchanged.
  - A pushed entry is never issued in its push cycle; the earliest issue is the next cycle.
  - Entries issue in push order.
- **Fill FSM states:**
  - IDLE → RUN on `fill_start` with `fill_len≠0`. Latches `cur=fill_addr`, `rem=fill_len`, and `fill_data`.
  - `fill_start` with `fill_len=0` has no effect.
  - `fill_start` while in RUN is ignored; the latched values are unchanged.
  - RUN → IDLE on the cycle a fill grant occurs with `rem=1`.
  - A fill of `rem=N` completes after exactly N fill grants.
- **`ovf`:**
  - Set by a dropped push.
  - `ovf_clr` clears it.
  - A drop and `ovf_clr` in the same cycle leave `ovf=1` (set wins).
- **Write collisions:** the later-issued write determines the final RAM content. A host write to an address inside an active fill range may therefore be overwritten by the fill.

## Timing
- **Reset values:** `disp_valid=0`, `host_full=0`, `fill_busy=0`, `ovf=0`. FIFO empty, FSM IDLE, `cur=0`, `rem=0`. Combinational RAM outputs are therefore `ram_addr=0`, `ram_wdata=0`, `ram_we=0`.
- **Reset mid-operation:** the FIFO is flushed and any fill is aborted. Pending entries are lost and no partial-write retry occurs.
- **Latencies:**
  - Display read: `disp_req` at cycle N → `disp_valid` and data at N+1.
  - Host write: push at N → RAM write at N+1 at the earliest.
  - Fill: `fill_start` at N → `fill_busy=1` at N+1 → first write at N+1 at the earliest.
  - `fill_busy` falls the cycle after the last fill write.
- **Throughput:**
  - Back-to-back grants are allowed.
  - Host and fill make no progress while `disp_req=1`. The display controllers leave idle cycles, so no starvation timer exists.
- **`host_full`** is registered and reflects count after the cycle's push/pop.

## Test plan
- **Display fetch:** `disp_req=1`, `disp_addr=0x0123`, RAM preloaded with 0x41 there → `ram_we=0` and `ram_addr=0x0123` in the same cycle; next cycle `disp_valid=1`, `disp_data=0x41`.
- **Host priority and ordering:**
  - Stimulus: push (0x0010,0xAA) then (0x0011,0xBB) while `disp_req=1` for 3 cycles.
  - Required: no writes during those 3 cycles, then 0x0010=0xAA followed by 0x0011=0xBB on consecutive cycles.
- **Overflow:**
  - Stimulus: hold `disp_req=1` and push 5 writes.
  - Required: `host_full=1` after the 4th push; the 5th write is dropped and `ovf=1`.
  - Stimulus: pulse `ovf_clr`.
  - Required: `ovf=0`; after `disp_req` drops, exactly 4 writes issue.
- **Fill with wrap:**
  - Stimulus: `fill_start`, `fill_addr=0xFFFE`, `fill_len=4`, `fill_data=0x20`.
  - Required: writes to 0xFFFE, 0xFFFF, 0x0000, 0x0001; `fill_busy` high for exactly 4 cycles when there is no contention.
  - Stimulus: `fill_start` with `fill_len=0`.
  - Required: no writes and `fill_busy` stays 0.
- **Three-way contention:**
  - Stimulus: a fill of length 8 running, display requesting on alternating cycles, plus one host push.
  - Required: display is served every requested cycle; the host write issues before the next fill write; all 8 fill writes complete; a `fill_start` issued during RUN is ignored.
- **Reset mid-fill:**
  - Stimulus: assert `rst` asynchronously after 2 of 6 fill writes, with 2 FIFO entries pending.
  - Required: all outputs take their reset values immediately; no further writes occur after `rst` deasserts.
